// File: rtl/silife_load_pkg.sv
// Shared types for the tile serial load-chain master.
package silife_load_pkg;

  localparam int LOAD_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    TAIL
  } load_state_t;

endpackage

// File: rtl/silife_load_phase_timer.sv
// Half-period timer for the load clock: counts CLK_DIV enabled cycles, strobes
// expire on the last one and rearms itself.
module silife_load_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(CLK_DIV + 1);
  localparam logic [TW-1:0] LAST = TW'(CLK_DIV - 1);

  logic [TW-1:0] cnt;

  assign expire = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/silife_load_master.sv
// Master end of the tile serial load chain: shifts byte-fed frames out MSB first
// and returns the bits coming back from the last tile as readback bytes.
module silife_load_master
  import silife_load_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [LOAD_BYTE_W-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_load_cs,
  output logic                   o_load_clk,
  output logic                   o_load_data,
  input  logic                   i_chain_data,
  output logic [LOAD_BYTE_W-1:0] o_rd_data,
  output logic                   o_rd_valid,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME_BITS);

  load_state_t            state;
  logic [LOAD_BYTE_W-1:0] tx;
  logic [LOAD_BYTE_W-1:0] rx;
  logic [BW-1:0]          bitcnt;
  logic [BW-1:0]          bit_next;
  logic [LOAD_BYTE_W-1:0] rx_next;
  logic                   byte_end;
  logic                   phase_en;
  logic                   phase_restart;
  logic                   phase_expire;

  frame_bits_legal: assert property (@(posedge clk)
    (FRAME_BITS % 8 == 0) && (FRAME_BITS >= 8) && (CLK_DIV >= 1));

  // Both serial outputs come straight off the shift registers.
  assign o_load_data = tx[LOAD_BYTE_W-1];
  assign o_rd_data   = rx;

  always_comb begin
    bit_next      = bitcnt + BW'(1);
    rx_next       = {rx[LOAD_BYTE_W-2:0], i_chain_data};
    byte_end      = (bit_next[2:0] == 3'd0);
    phase_en      = ((state == SHIFT_LO) || (state == SHIFT_HI) || (state == TAIL)) && !o_done;
    phase_restart = (state == IDLE) || (state == FETCH);
  end

  silife_load_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (phase_restart),
    .en      (phase_en),
    .expire  (phase_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tx         <= '0;
      rx         <= '0;
      bitcnt     <= '0;
      o_ready    <= 1'b0;
      o_load_cs  <= 1'b0;
      o_load_clk <= 1'b0;
      o_rd_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= FETCH;
            o_load_cs <= 1'b1;
            o_busy    <= 1'b1;
            o_ready   <= 1'b1;
            bitcnt    <= '0;
          end
        end
        FETCH: begin
          if (i_valid) begin
            tx      <= i_data;
            o_ready <= 1'b0;
            state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (phase_expire) begin
            o_load_clk <= 1'b1;
            state      <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          // Sample at the end of the high phase; the next data bit is only
          // presented once the clock is low again.
          if (phase_expire) begin
            rx         <= rx_next;
            bitcnt     <= bit_next;
            o_load_clk <= 1'b0;
            o_rd_valid <= byte_end;
            if (bit_next == FRAME_LAST) begin
              state <= TAIL;
            end else if (byte_end) begin
              state   <= FETCH;
              o_ready <= 1'b1;
            end else begin
              tx    <= {tx[LOAD_BYTE_W-2:0], 1'b0};
              state <= SHIFT_LO;
            end
          end
        end
        TAIL: begin
          // The done cycle is still part of TAIL, so a start landing on it is dropped.
          if (o_done) begin
            o_done <= 1'b0;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else if (phase_expire) begin
            o_load_cs <= 1'b0;
            o_done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/silife_load_master.md
Name: silife_load_master

Overview:
- Master end of the tile serial load chain. Drives the chain's chip-select, load clock and data lines: cs into every tile, data into the first tile.
- Shifts out frames of FRAME_BITS bits, supplied as bytes over a valid/ready interface, MSB first.
- Captures the bits returning from the last tile's data output and returns them as readback bytes.
- Sits in the top-level harness/controller next to the tile grid. The tiles are the receivers.

Parameters:
- CLK_DIV, 2, clk cycles per half-period of o_load_clk (≥1).
- FRAME_BITS, 64, bits per frame. Must be a multiple of 8 and ≥8; simulation assertion checks this.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- i_start  input  1  one-cycle pulse; begins a frame. Honoured only in IDLE, ignored otherwise.
- i_data  input  8  next byte to shift, MSB first.
- i_valid  input  1  i_data valid.
- o_ready  output  1  byte accepted this cycle when i_valid & o_ready.
- o_load_cs  output  1  chain select, active-high, to every tile.
- o_load_clk  output  1  chain shift clock, to every tile.
- o_load_data  output  1  serial data into the first tile.
- i_chain_data  input  1  serial data out of the last tile.
- o_rd_data  output  8  readback byte.
- o_rd_valid  output  1  one-cycle strobe for o_rd_data. No backpressure.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (async assert, sync deassert): state IDLE, all outputs 0, counters and shift registers cleared. Reset mid-frame drops cs immediately and the frame is lost.
- State IDLE: on i_start, go to FETCH and raise o_load_cs in the next cycle.
- State FETCH: o_ready=1.
  - On i_valid, load the TX shift register with i_data and go to SHIFT_LO.
  - If no byte arrives, o_load_clk stays low indefinitely (stall, no timeout). cs stays high.
- State SHIFT_LO: o_load_clk=0 and o_load_data=tx[7] for CLK_DIV cycles, then SHIFT_HI.
- State SHIFT_HI: o_load_clk=1 for CLK_DIV cycles.
  - o_load_data is held; it only changes while the clock is low.
  - On the last cycle of the phase, sample i_chain_data into the RX shift register (LSB in, left shift) and increment the bit counter.
  - Next state: TAIL if the bit counter = FRAME_BITS; else FETCH if bit count mod 8 = 0; else SHIFT_LO with TX shifted left.
- Readback: o_rd_valid pulses the cycle after every 8th sample, with o_rd_data = last 8 sampled bits, first sampled bit in [7]. Readback data is the previous chain contents, returned in order.
- State TAIL: o_load_clk=0, cs high for CLK_DIV cycles. Then cs falls, o_done pulses for 1 cycle, state returns to IDLE.
- Counters:
  - Bit counter width $clog2(FRAME_BITS+1).
  - Phase counter width $clog2(CLK_DIV+1).
  - Both reset to 0 on every phase or frame entry. No wrap is reachable.
- Simultaneous events:
  - i_start together with the o_done cycle is ignored (state is not yet IDLE).
  - i_valid outside FETCH is not accepted.
- Throughput with a byte always valid: 8·2·CLK_DIV + 1 cycles per byte.

Decomposition:
- Package silife_load_pkg: state enum (IDLE, FETCH, SHIFT_LO, SHIFT_HI, TAIL) and byte-width constant LOAD_BYTE_W=8.
- Sub-module silife_load_phase_timer: CLK_DIV half-period counter with restart input and expiry strobe, reused for SHIFT_LO, SHIFT_HI and TAIL.

Test Plan:
- Reset: assert reset low mid-SHIFT_HI -> cs, clk, data, busy all 0 in the same cycle. After release, stays IDLE until i_start.
- Basic frame (CLK_DIV=2, FRAME_BITS=16):
  - Stimulus: i_start, then bytes 0xA5 and 0x3C always valid.
  - Required: o_load_data sequence 1010_0101_0011_1100, each bit stable across the rising edge.
  - Required: exactly 16 rising edges of o_load_clk, one o_done pulse, o_busy low afterwards.
- Readback loop: tie i_chain_data to a 16-bit model chain preloaded with 0xBEEF -> o_rd_valid twice with 0xBE then 0xEF. Model then holds 0xA53C.
- Stall: delay second byte's i_valid by 20 cycles -> o_load_clk low and cs high throughout, no extra clock edges, data correct.
- Back-to-back: i_start asserted the same cycle as o_done -> ignored. i_start one cycle later -> new frame, with cs low ≥1 cycle between frames.
- CLK_DIV=1 corner: 8-bit frame 0xFF -> o_load_clk toggles every cycle, 8 rising edges, byte took 17 cycles from acceptance to TAIL.
